// File: rtl/nvme_host_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready request into AW/W/B or AR/R
// sequences towards the NVMe host slave port, with a sticky stall monitor.
module nvme_host_lite_master #(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 rsp_timeout,
    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [31:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    output logic                 busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = {{(ADDR_BITS-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [31:0]            wdata_r;
    logic [3:0]             wstrb_r;
    logic                   aw_done_r;
    logic                   w_done_r;
    logic [31:0]            rsp_rdata_r;
    logic [1:0]             rsp_resp_r;
    logic                   rsp_timeout_r;
    logic [CNT_W-1:0]       stall_cnt_r;
    logic                   stall_flag_r;
    logic                   accept_s;
    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   active_s;
    logic                   stall_hit_s;

    assign accept_s    = (state_r == ST_IDLE) && req_valid;
    assign aw_hs_s     = m_axi_awvalid && m_axi_awready;
    assign w_hs_s      = m_axi_wvalid && m_axi_wready;
    assign active_s    = (state_r == ST_WR_AW_W) || (state_r == ST_WR_B) ||
                         (state_r == ST_RD_AR)   || (state_r == ST_RD_R);
    assign stall_hit_s = (TIMEOUT_CYCLES != 0) && (stall_cnt_r == TO_VAL);

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_s = req_write ? ST_WR_AW_W : ST_RD_AR;
                else           state_s = ST_IDLE;
            end
            ST_WR_AW_W: begin
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) state_s = ST_WR_B;
                else                                                 state_s = ST_WR_AW_W;
            end
            ST_WR_B: begin
                if (m_axi_bvalid) state_s = ST_RSP;
                else              state_s = ST_WR_B;
            end
            ST_RD_AR: begin
                if (m_axi_arready) state_s = ST_RD_R;
                else               state_s = ST_RD_AR;
            end
            ST_RD_R: begin
                if (m_axi_rvalid) state_s = ST_RSP;
                else              state_s = ST_RD_R;
            end
            ST_RSP: begin
                if (rsp_ready) state_s = ST_IDLE;
                else           state_s = ST_RSP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state and per-channel done flags
    always_comb begin
        req_ready     = (state_r == ST_IDLE);
        m_axi_awvalid = (state_r == ST_WR_AW_W) && !aw_done_r;
        m_axi_wvalid  = (state_r == ST_WR_AW_W) && !w_done_r;
        m_axi_bready  = (state_r == ST_WR_B);
        m_axi_arvalid = (state_r == ST_RD_AR);
        m_axi_rready  = (state_r == ST_RD_R);
        rsp_valid     = (state_r == ST_RSP);
        busy          = (state_r != ST_IDLE);
    end

    assign m_axi_awaddr = addr_r;
    assign m_axi_araddr = addr_r;
    assign m_axi_wdata  = wdata_r;
    assign m_axi_wstrb  = wstrb_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_resp     = rsp_resp_r;
    assign rsp_timeout  = rsp_timeout_r;

    // Request capture, channel completion tracking and response capture
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            addr_r        <= {ADDR_BITS{1'b0}};
            wdata_r       <= 32'd0;
            wstrb_r       <= 4'd0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            rsp_rdata_r   <= 32'd0;
            rsp_resp_r    <= 2'd0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r    <= req_addr & ALIGN_MASK;
                        wdata_r   <= req_wdata;
                        wstrb_r   <= req_wstrb;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                    end
                end
                ST_WR_AW_W: begin
                    if (aw_hs_s) aw_done_r <= 1'b1;
                    if (w_hs_s)  w_done_r  <= 1'b1;
                end
                ST_WR_B: begin
                    if (m_axi_bvalid) begin
                        rsp_rdata_r   <= 32'd0;
                        rsp_resp_r    <= m_axi_bresp;
                        rsp_timeout_r <= stall_flag_r || stall_hit_s;
                    end
                end
                ST_RD_R: begin
                    if (m_axi_rvalid) begin
                        rsp_rdata_r   <= m_axi_rdata;
                        rsp_resp_r    <= m_axi_rresp;
                        rsp_timeout_r <= stall_flag_r || stall_hit_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating stall counter and sticky timeout flag, both cleared on accept
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            stall_flag_r <= 1'b0;
        end else if (accept_s) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            stall_flag_r <= 1'b0;
        end else begin
            if (active_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            if (stall_hit_s) stall_flag_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nvme_host_lite_master.sv
// Directed bench for nvme_host_lite_master acting as the AXI-Lite slave by hand.
module tb_nvme_host_lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, busy;
    logic [1:0]  bresp, rresp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nvme_host_lite_master #(.ADDR_BITS(32), .TIMEOUT_CYCLES(16)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic send_req(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata,
                            input logic [1:0] exp_resp, input logic exp_to);
        int k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_resp"}, rsp_resp, exp_resp);
        check({tag, "_timeout"}, rsp_timeout, exp_to);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rsp_valid, 0);
        check({tag, "_back_idle"}, req_ready, 1);
    endtask

    // Write with AW and W accepted together, then bvalid after bdelay cycles.
    task automatic fast_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [1:0] br, input int bdelay);
        int drops = 0;
        send_req(1'b1, addr, wd, ws);
        check({tag, "_aw_w_valid"}, {awvalid, wvalid}, 2'b11);
        check({tag, "_awaddr"}, awaddr, addr & 32'hFFFF_FFFC);
        check({tag, "_wdata"}, wdata, wd);
        check({tag, "_wstrb"}, wstrb, ws);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        check({tag, "_aw_w_drop"}, {awvalid, wvalid}, 2'b00);
        for (int i = 0; i < bdelay; i++) begin
            if (!bready || !busy) drops++;
            @(negedge clk);
        end
        check({tag, "_bready_held"}, drops, 0);
        bvalid = 1'b1; bresp = br;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'd0;
        check({tag, "_bready_drop"}, bready, 0);
    endtask

    // Starts at the negedge where arvalid should be up.
    task automatic finish_read(input string tag, input logic [31:0] exp_araddr,
                               input logic [31:0] rd, input logic [1:0] rr);
        check({tag, "_arvalid"}, arvalid, 1);
        check({tag, "_araddr"}, araddr, exp_araddr);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check({tag, "_ar_drop_rready"}, {arvalid, rready}, 2'b01);
        rvalid = 1'b1; rdata = rd; rresp = rr;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        check({tag, "_rready_drop"}, rready, 0);
    endtask

    // AW and W complete three cycles apart, in the chosen order.
    task automatic wr_split(input string tag, input bit aw_first);
        int early_b = 0;
        int bad_valid = 0;
        send_req(1'b1, 32'h0000_0050, 32'hCAFE_0000, 4'hC);
        check({tag, "_both_valid"}, {awvalid, wvalid}, 2'b11);
        if (aw_first) awready = 1'b1; else wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bready) early_b++;
            if (aw_first ? (awvalid || !wvalid) : (wvalid || !awvalid)) bad_valid++;
            if (i < 2) @(negedge clk);
        end
        check({tag, "_bready_early"}, early_b, 0);
        check({tag, "_first_drop_only"}, bad_valid, 0);
        check({tag, "_addr_stable"}, {awaddr, wdata}, {32'h0000_0050, 32'hCAFE_0000});
        if (aw_first) wready = 1'b1; else awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        check({tag, "_second_drop"}, {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'd0;
        @(negedge clk);
        bvalid = 1'b0;
        wait_rsp(tag, 32'd0, 2'd0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy}, 7'd0);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'd0);
        rst_n = 1'b1;
        @(negedge clk);

        fast_write("wr_basic", 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 2'd0, 2);
        wait_rsp("wr_basic", 32'd0, 2'd0, 1'b0);

        wr_split("wr_w_first", 1'b0);
        wr_split("wr_aw_first", 1'b1);

        send_req(1'b0, 32'h0000_001F, 32'd0, 4'd0);
        finish_read("rd_unal", 32'h0000_001C, 32'h1234_5678, 2'd2);
        wait_rsp("rd_unal", 32'h1234_5678, 2'd2, 1'b0);

        fast_write("wr_slow", 32'h0000_0024, 32'h0000_00AA, 4'h1, 2'd0, 40);
        wait_rsp("wr_slow", 32'd0, 2'd0, 1'b1);
        send_req(1'b0, 32'h0000_0020, 32'd0, 4'd0);
        finish_read("rd_fast", 32'h0000_0020, 32'h0BAD_F00D, 2'd0);
        wait_rsp("rd_fast", 32'h0BAD_F00D, 2'd0, 1'b0);

        // Response back-pressure with a pending second request
        fast_write("wr_hold", 32'h0000_0030, 32'h1122_3344, 4'h3, 2'd2, 1);
        check("hold_rsp_valid", rsp_valid, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready || !rsp_valid || rsp_resp != 2'd2 || rsp_rdata != 32'd0) bad++;
            @(negedge clk);
        end
        check("hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_release", {rsp_valid, req_ready}, 2'b01);
        @(negedge clk);
        req_valid = 1'b0;
        finish_read("rd_after_hold", 32'h0000_0040, 32'hA5A5_0001, 2'd0);
        wait_rsp("rd_after_hold", 32'hA5A5_0001, 2'd0, 1'b0);

        // Reset pulse while waiting for R
        send_req(1'b0, 32'h0000_0008, 32'd0, 4'd0);
        check("rst_arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rst_in_rd_r", rready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {arvalid, rready, rsp_valid, busy}, 4'd0);
        check("rst_mid_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle", {req_ready, busy}, 2'b10);
        send_req(1'b0, 32'h0000_0044, 32'd0, 4'd0);
        finish_read("rd_post_rst", 32'h0000_0044, 32'h5555_AAAA, 2'd0);
        wait_rsp("rd_post_rst", 32'h5555_AAAA, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
